ift_trace_recorder: RTL and testbench

- Capture-side counterpart of the IFT stimulus player that replays {a_t, b_t, t} records from a memory file.
- Samples a packed taint vector every clock and run-length encodes it into records {taint_0 .. taint_N-1, duration}.
- Record layout and bit order are identical to the player's input format, so recorded traces replay directly.
- Records are buffered in a FIFO and drained over a valid/ready port by a bench or writer.

---
 rtl/ift_trace_pkg.sv | 23 ++
 rtl/ift_trace_fifo.sv | 72 +++++++
 rtl/ift_trace_recorder.sv | 138 +++++++++++++
 tb/tb_ift_trace_recorder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ift_trace_pkg.sv
// ift_trace_pkg
//   Shared definitions for the IFT trace recorder and the stimulus player
//   bench: recorder state encoding, default field widths and a helper that
//   computes the width of one {taints, duration} record.
package ift_trace_pkg;

  localparam int TAINT_W_DEF = 32;
  localparam int NUM_SIG_DEF = 2;
  localparam int DUR_W_DEF   = 32;
  localparam int DEPTH_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Width of one record: all taint signals followed by the duration field.
  function automatic int rec_w(input int num_sig, input int taint_w, input int dur_w);
    return num_sig * taint_w + dur_w;
  endfunction

endpackage

// File: rtl/ift_trace_fifo.sv
// ift_trace_fifo
//   Synchronous first-word-fall-through FIFO for trace records.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     push       write request; push_data is written when accept=1
//     accept     push is taken this cycle (not full, or full with a pop)
//     full       FIFO holds DEPTH entries
//     pop        read request; only honoured when not empty
//     empty      FIFO holds no entries
//     head       current head entry, zero when empty
//     level      occupancy, 0..DEPTH
//
//   Handshake: an entry leaves when pop=1 and empty=0 at a rising edge.
//   head is stable until that edge. A push into a full FIFO succeeds only
//   when a pop happens in the same cycle; the write then lands in the slot
//   being vacated, so level stays at DEPTH.
import ift_trace_pkg::*;

module ift_trace_fifo #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     accept,
  output logic                     full,
  input  logic                     pop,
  output logic                     empty,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  assign full   = (level == FULL_LVL);
  assign empty  = (level == '0);
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  // Head reads as zero while empty so the output is clean after reset.
  assign head   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/ift_trace_recorder.sv
// ift_trace_recorder
//   Samples a packed taint vector every clock while recording and
//   run-length encodes it into {taint_0 .. taint_N-1, duration} records,
//   the same layout the IFT stimulus player consumes.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     start_i       begin recording (IDLE only)
//     stop_i        end recording and flush the pending record (RUN only)
//     sample_i      packed taints, signal 0 in the MSBs
//     rec_valid_o   record available at the FIFO head
//     rec_ready_i   consumer takes the head record
//     rec_data_o    {taints, duration}, duration in the LSBs
//     busy_o        recorder is not IDLE
//     overflow_o    sticky: a record was dropped since the last start
//     level_o       FIFO occupancy
//     dbg_state     current FSM state
//
//   Handshake: a record is transferred on a rising edge where
//   rec_valid_o=1 and rec_ready_i=1; rec_data_o holds while stalled.
import ift_trace_pkg::*;

module ift_trace_recorder #(
  parameter int TAINT_W = TAINT_W_DEF,
  parameter int NUM_SIG = NUM_SIG_DEF,
  parameter int DUR_W   = DUR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  logic                            stop_i,
  input  logic [NUM_SIG*TAINT_W-1:0]      sample_i,
  output logic                            rec_valid_o,
  input  logic                            rec_ready_i,
  output logic [NUM_SIG*TAINT_W+DUR_W-1:0] rec_data_o,
  output logic                            busy_o,
  output logic                            overflow_o,
  output logic [$clog2(DEPTH):0]          level_o,
  output logic [1:0]                      dbg_state
);

  localparam int SW    = NUM_SIG * TAINT_W;
  localparam int REC_W = rec_w(NUM_SIG, TAINT_W, DUR_W);
  localparam logic [DUR_W-1:0] ONE = {{(DUR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [SW-1:0]    held_q, held_d;
  logic [DUR_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic             push;
  logic             accept;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] push_data;

  assign push_data = {held_q, count_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          held_d  = sample_i;
          count_d = ONE;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = FLUSH;
        end else if (sample_i != held_q) begin
          push    = 1'b1;
          held_d  = sample_i;
          count_d = ONE;
        end else if (count_q == '1) begin
          // Duration field saturated: close this run and start a new one
          // with the same taint value.
          push    = 1'b1;
          count_d = ONE;
        end else begin
          count_d = count_q + ONE;
        end
        // A refused push loses the record but the run tracking continues.
        if (push && fifo_full && !(rec_valid_o && rec_ready_i)) begin
          ovf_d = 1'b1;
        end
      end
      FLUSH: begin
        // Retry every cycle until the FIFO takes the final record.
        push = 1'b1;
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ift_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .accept    (accept),
    .full      (fifo_full),
    .pop       (rec_ready_i),
    .empty     (fifo_empty),
    .head      (rec_data_o),
    .level     (level_o)
  );

  assign rec_valid_o = !fifo_empty;
  assign busy_o      = (state_q != IDLE);
  assign overflow_o  = ovf_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ift_trace_recorder.sv
// Bench for ift_trace_recorder. Two instances share clock and stimulus:
// u_big uses default widths, u_small uses DUR_W=4 and DEPTH=4 for the
// saturation and overflow corner cases. Each has its own ready input.
import ift_trace_pkg::*;

module tb_ift_trace_recorder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [63:0] sample = '0;

  logic        ready0 = 1'b0, ready1 = 1'b0;
  logic        valid0, valid1, busy0, busy1, ovf0, ovf1;
  logic [95:0] data0;
  logic [67:0] data1;
  logic [4:0]  level0;
  logic [2:0]  level1;
  logic [1:0]  st0, st1;

  int compared = 0;
  int failed   = 0;

  logic [95:0] exp_q[$];
  logic [95:0] got_q[$];

  always #5 clk = ~clk;

  ift_trace_recorder u_big (
    .clk (clk), .rst (rst), .start_i (start), .stop_i (stop),
    .sample_i (sample), .rec_valid_o (valid0), .rec_ready_i (ready0),
    .rec_data_o (data0), .busy_o (busy0), .overflow_o (ovf0),
    .level_o (level0), .dbg_state (st0)
  );

  ift_trace_recorder #(.TAINT_W(32), .NUM_SIG(2), .DUR_W(4), .DEPTH(4)) u_small (
    .clk (clk), .rst (rst), .start_i (start), .stop_i (stop),
    .sample_i (sample), .rec_valid_o (valid1), .rec_ready_i (ready1),
    .rec_data_o (data1), .busy_o (busy1), .overflow_o (ovf1),
    .level_o (level1), .dbg_state (st1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [95:0] rec0(input logic [63:0] s, input int d);
    return {s, 32'(d)};
  endfunction

  function automatic logic [95:0] rec1(input logic [63:0] s, input int d);
    return {28'b0, s, 4'(d)};
  endfunction

  function automatic logic [63:0] sv(input int i);
    return {32'h10 + 32'(i), 32'h100 + 32'(i)};
  endfunction

  function automatic logic cur_valid(input int sel);
    return (sel == 0) ? valid0 : valid1;
  endfunction

  function automatic logic [95:0] cur_data(input int sel);
    return (sel == 0) ? data0 : {28'b0, data1};
  endfunction

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; stop = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Start cycle counts as the first cycle of the first segment.
  task automatic start_rec(input logic [63:0] s, input int n);
    sample = s; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (n - 1) tick;
  endtask

  task automatic seg(input logic [63:0] s, input int n);
    sample = s;
    repeat (n) tick;
  endtask

  task automatic stop_rec;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  task automatic wait_idle(input int sel, input string name);
    int w = 0;
    while (((sel == 0) ? busy0 : busy1) && w < 50) begin
      tick; w++;
    end
    check(name, {95'b0, ((sel == 0) ? busy0 : busy1)}, 96'd0);
  endtask

  // Pop every expected record in order, comparing each head.
  task automatic drain(input int sel, input string name);
    while (exp_q.size() > 0) begin
      int w = 0;
      logic [95:0] e;
      e = exp_q.pop_front();
      while (!cur_valid(sel) && w < 50) begin
        tick; w++;
      end
      if (!cur_valid(sel)) begin
        check({name, "_timeout"}, 96'd0, 96'd1);
        exp_q.delete();
        break;
      end
      check(name, cur_data(sel), e);
      got_q.push_back(cur_data(sel));
      if (sel == 0) ready0 = 1'b1; else ready1 = 1'b1;
      tick;
      ready0 = 1'b0; ready1 = 1'b0;
    end
  endtask

  typedef struct {
    logic [63:0] sample;
    int          cycles;
    logic [95:0] exp_rec;
  } vec_t;

  vec_t        vecs[4];
  logic [63:0] applied_q[$];
  logic [63:0] recon_q[$];

  initial begin
    int sum;
    int diffs;

    vecs[0] = '{64'h0000_0000_0000_0000, 8, rec0(64'h0000_0000_0000_0000, 8)};
    vecs[1] = '{64'h0000_0000_0000_0001, 8, rec0(64'h0000_0000_0000_0001, 8)};
    vecs[2] = '{64'h0000_0001_0000_0000, 8, rec0(64'h0000_0001_0000_0000, 8)};
    vecs[3] = '{64'h0000_0001_0000_0001, 8, rec0(64'h0000_0001_0000_0001, 8)};

    // Reset state
    do_reset;
    check("rst_valid0", {95'b0, valid0}, 96'd0);
    check("rst_busy0",  {95'b0, busy0},  96'd0);
    check("rst_ovf0",   {95'b0, ovf0},   96'd0);
    check("rst_level0", {91'b0, level0}, 96'd0);
    check("rst_data0",  data0,           96'd0);
    check("rst_valid1", {95'b0, valid1}, 96'd0);
    check("rst_data1",  {28'b0, data1},  96'd0);

    // Constant input for 5 cycles
    start_rec(64'h0000_0001_0000_0002, 5);
    stop_rec;
    wait_idle(0, "const_idle");
    exp_q.push_back({32'h1, 32'h2, 32'd5});
    drain(0, "const_rec");
    check("const_ovf",   {95'b0, ovf0},   96'd0);
    check("const_level", {91'b0, level0}, 96'd0);

    // Player-vector replay, table driven
    do_reset;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) start_rec(vecs[i].sample, vecs[i].cycles);
      else        seg(vecs[i].sample, vecs[i].cycles);
      for (int c = 0; c < vecs[i].cycles; c++) applied_q.push_back(vecs[i].sample);
      exp_q.push_back(vecs[i].exp_rec);
    end
    stop_rec;
    wait_idle(0, "replay_idle");
    drain(0, "replay_rec");
    sum = 0;
    foreach (got_q[k]) begin
      sum += int'(got_q[k][31:0]);
      for (int c = 0; c < int'(got_q[k][31:0]) && c < 64; c++) recon_q.push_back(got_q[k][95:32]);
    end
    check("replay_dur_sum", 96'(sum), 96'd32);
    check("replay_wave_len", 96'(recon_q.size()), 96'(applied_q.size()));
    diffs = 0;
    foreach (applied_q[k]) if (k >= recon_q.size() || recon_q[k] !== applied_q[k]) diffs++;
    check("replay_wave_diffs", 96'(diffs), 96'd0);

    // Saturation split with DUR_W=4
    do_reset;
    start_rec(64'hDEAD_0000_BEEF_0001, 20);
    stop_rec;
    wait_idle(1, "sat_idle");
    exp_q.push_back(rec1(64'hDEAD_0000_BEEF_0001, 15));
    exp_q.push_back(rec1(64'hDEAD_0000_BEEF_0001, 5));
    drain(1, "sat_rec");
    check("sat_ovf", {95'b0, ovf1}, 96'd0);

    // Overflow with DEPTH=4: 7 samples, 6 RUN pushes, 2 dropped
    do_reset;
    start_rec(sv(0), 1);
    for (int i = 1; i < 7; i++) seg(sv(i), 1);
    stop_rec;
    tick;
    check("ovf_level", {93'b0, level1}, 96'd4);
    check("ovf_flag",  {95'b0, ovf1},   96'd1);
    check("ovf_busy_flush", {95'b0, busy1}, 96'd1);
    check("ovf_head0", {28'b0, data1}, rec1(sv(0), 1));
    ready1 = 1'b1;
    tick;
    ready1 = 1'b0;
    check("ovf_level_after_pop", {93'b0, level1}, 96'd4);
    check("ovf_idle_after_pop",  {95'b0, busy1},  96'd0);
    for (int i = 1; i < 4; i++) exp_q.push_back(rec1(sv(i), 1));
    exp_q.push_back(rec1(sv(6), 1));
    drain(1, "ovf_rec");
    check("ovf_sticky", {95'b0, ovf1}, 96'd1);

    // Full FIFO with simultaneous push and pop in RUN
    do_reset;
    start_rec(sv(0), 1);
    for (int i = 1; i < 5; i++) seg(sv(i), 1);
    check("pp_level_full", {93'b0, level1}, 96'd4);
    sample = sv(5); ready1 = 1'b1;
    tick;
    ready1 = 1'b0;
    check("pp_level_kept", {93'b0, level1}, 96'd4);
    check("pp_no_ovf",     {95'b0, ovf1},   96'd0);
    stop_rec;
    for (int i = 1; i < 5; i++) exp_q.push_back(rec1(sv(i), 1));
    exp_q.push_back(rec1(sv(5), 1));
    drain(1, "pp_rec");
    wait_idle(1, "pp_idle");

    // Reset in the middle of a recording
    do_reset;
    start_rec(sv(0), 1);
    for (int i = 1; i < 4; i++) seg(sv(i), 1);
    check("mid_level", {91'b0, level0}, 96'd3);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_valid", {95'b0, valid0}, 96'd0);
    check("mid_level0", {91'b0, level0}, 96'd0);
    check("mid_state", {94'b0, st0}, 96'(IDLE));
    stop_rec;
    check("mid_stop_busy",  {95'b0, busy0},  96'd0);
    check("mid_stop_valid", {95'b0, valid0}, 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
